// File: rtl/instr_mem_loader_pkg.sv
// Shared constants, state encoding and helpers for the UART-to-instruction-memory loader.
package instr_mem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned NB_BYTE        = 8;
  localparam int unsigned NB_CNT         = 2;
  localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // True when the byte being accepted completes a word.
  function automatic logic is_last_byte(input logic [NB_CNT-1:0] cnt);
    return cnt == NB_CNT'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Assembles big-endian 32-bit words from a UART byte stream and writes them
// sequentially to instruction memory until a halt word or the end of memory.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned          NB_DATA   = 32,
  parameter int unsigned          NB_ADDR   = 12,
  parameter logic [NB_DATA-1:0]   HALT_WORD = NB_DATA'(HALT_WORD_DEF)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_we,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow
);

  localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(BYTES_PER_WORD);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = ~NB_ADDR'(BYTES_PER_WORD - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [NB_CNT-1:0]   r_cnt;
  logic [NB_CNT-1:0]   w_cnt_nxt;
  logic [NB_DATA-1:0]  r_shift;
  logic [NB_DATA-1:0]  w_shift_nxt;
  logic [NB_DATA-1:0]  w_word;
  logic [NB_DATA-1:0]  w_data_nxt;
  logic [NB_ADDR-1:0]  w_addr_nxt;
  logic                w_we_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_ovf_nxt;

  // Incoming byte enters at the bottom; after four shifts the first byte sits in the MSBs.
  assign w_word = {r_shift[NB_DATA-NB_BYTE-1:0], i_rx_data};

  // Next-state, byte assembler and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = o_data;
    w_addr_nxt  = o_addr;
    w_ovf_nxt   = o_overflow;
    w_we_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_addr_nxt  = '0;
        end
      end

      RECV: begin
        if (i_rx_valid) begin
          w_shift_nxt = w_word;
          if (is_last_byte(r_cnt)) begin
            w_data_nxt  = w_word;
            w_cnt_nxt   = '0;
            w_state_nxt = WRITE;
          end else begin
            w_cnt_nxt = r_cnt + NB_CNT'(1);
          end
        end
      end

      WRITE: begin
        // A byte arriving during the write strobe starts the next word.
        if (i_rx_valid) begin
          w_shift_nxt = w_word;
          w_cnt_nxt   = NB_CNT'(1);
        end
        if (o_data == HALT_WORD) begin
          w_state_nxt = DONE;
        end else if (o_addr == LAST_ADDR) begin
          w_state_nxt = DONE;
          w_ovf_nxt   = 1'b1;
        end else begin
          w_state_nxt = RECV;
          w_addr_nxt  = o_addr + ADDR_STEP;
        end
      end

      DONE: begin
        if (i_start) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_addr_nxt  = '0;
          w_ovf_nxt   = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_we_nxt   = (w_state_nxt == WRITE);
    w_busy_nxt = (w_state_nxt == RECV) || (w_state_nxt == WRITE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      o_we       <= 1'b0;
      o_data     <= '0;
      o_addr     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      o_we       <= w_we_nxt;
      o_data     <= w_data_nxt;
      o_addr     <= w_addr_nxt;
      o_busy     <= w_busy_nxt;
      o_done     <= w_done_nxt;
      o_overflow <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed and randomized byte streams
// compared against a word-grouping reference model of expected memory writes.
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, rx_valid_a, start_b, rx_valid_b;
  logic [7:0]  rx_data_a, rx_data_b;
  logic        we_a, busy_a, done_a, ovf_a;
  logic        we_b, busy_b, done_b, ovf_b;
  logic [31:0] data_a, data_b;
  logic [11:0] addr_a;
  logic [3:0]  addr_b;

  instr_mem_loader #(.NB_DATA(32), .NB_ADDR(12)) u_dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_rx_data(rx_data_a),
    .i_rx_valid(rx_valid_a), .o_we(we_a), .o_data(data_a), .o_addr(addr_a),
    .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a)
  );

  instr_mem_loader #(.NB_DATA(32), .NB_ADDR(4)) u_dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_rx_data(rx_data_b),
    .i_rx_valid(rx_valid_b), .o_we(we_b), .o_data(data_b), .o_addr(addr_b),
    .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b)
  );

  int total = 0;
  int bad   = 0;

  logic [47:0] got_a[$];
  logic [47:0] got_b[$];
  logic [47:0] got[$];
  logic [47:0] exp_q[$];
  logic [7:0]  bytes_q[$];
  logic        dbl_we = 1'b0;
  logic        prev_we_a = 1'b0;
  logic        prev_we_b = 1'b0;

  // Record every memory write as {addr, data}; flag any strobe longer than one cycle.
  always @(negedge clk) begin
    if (we_a) got_a.push_back({16'(addr_a), data_a});
    if (we_b) got_b.push_back({16'(addr_b), data_b});
    if ((we_a && prev_we_a) || (we_b && prev_we_b)) dbl_we <= 1'b1;
    prev_we_a <= we_a;
    prev_we_b <= we_b;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit to_b, input logic [7:0] b, input int gap);
    if (to_b) begin rx_data_b = b; rx_valid_b = 1'b1; end
    else      begin rx_data_a = b; rx_valid_a = 1'b1; end
    bytes_q.push_back(b);
    tick();
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input bit to_b, input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(to_b, w[31-8*i -: 8], gap);
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic clear_hist();
    bytes_q.delete();
    got_a.delete();
    got_b.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h1234_5678;
    return w;
  endfunction

  // Reference: bytes group into big-endian words at consecutive word addresses;
  // the load stops after the halt word or after the last address of memory.
  task automatic build_exp(input int nb_addr);
    int nw;
    int last;
    int a;
    logic [31:0] w;
    exp_q.delete();
    nw   = bytes_q.size() / 4;
    last = (1 << nb_addr) - 4;
    for (int k = 0; k < nw; k++) begin
      w = {bytes_q[4*k], bytes_q[4*k+1], bytes_q[4*k+2], bytes_q[4*k+3]};
      a = (4 * k) % (1 << nb_addr);
      exp_q.push_back({16'(a), w});
      if (w == HALT || a == last) break;
    end
  endtask

  task automatic cmp_writes(input string tag, input bit from_b);
    int n;
    if (from_b) got = got_b; else got = got_a;
    chk({tag, "_count"}, 48'(got.size()), 48'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), got[i], exp_q[i]);
  endtask

  initial begin
    int nw;
    rst_n = 1'b0;
    start_a = 1'b0; rx_valid_a = 1'b0; rx_data_a = 8'h00;
    start_b = 1'b0; rx_valid_b = 1'b0; rx_data_b = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we",   48'(we_a),   48'(0));
    chk("rst_data", 48'(data_a), 48'(0));
    chk("rst_addr", 48'(addr_a), 48'(0));
    chk("rst_flags", 48'({busy_a, done_a, ovf_a}), 48'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Idle ignores bytes
    send(1'b0, 8'h55, 1);
    chk("idle_busy", 48'(busy_a), 48'(0));
    clear_hist();

    // First word 01 02 03 04
    pulse_start(1'b0);
    chk("start_busy", 48'(busy_a), 48'(1));
    send(1'b0, 8'h01, 1); send(1'b0, 8'h02, 0); send(1'b0, 8'h03, 2); send(1'b0, 8'h04, 0);
    chk("w1_we",   48'(we_a),   48'(1));
    chk("w1_data", 48'(data_a), 48'(32'h0102_0304));
    chk("w1_addr", 48'(addr_a), 48'(0));
    chk("w1_busy", 48'(busy_a), 48'(1));
    tick();
    chk("w1_we_drop", 48'(we_a),   48'(0));
    chk("w1_addr_inc", 48'(addr_a), 48'(4));
    // Partial word must not be written
    send(1'b0, 8'h77, 0); send(1'b0, 8'h88, 3);
    build_exp(12);
    cmp_writes("partial", 1'b0);

    // Two words then halt
    do_reset();
    clear_hist();
    pulse_start(1'b0);
    send_word(1'b0, rnd_word(), $urandom_range(0, 2));
    send_word(1'b0, rnd_word(), $urandom_range(0, 2));
    send_word(1'b0, HALT, $urandom_range(0, 2));
    repeat (3) tick();
    build_exp(12);
    cmp_writes("halt", 1'b0);
    chk("halt_flags", 48'({done_a, busy_a, ovf_a}), 48'(3'b100));
    for (int i = 0; i < 5; i++) send(1'b0, 8'($urandom), 0);
    repeat (2) tick();
    build_exp(12);
    cmp_writes("done_ignore", 1'b0);

    // Restart from DONE
    pulse_start(1'b0);
    chk("restart_flags", 48'({done_a, busy_a, ovf_a}), 48'(3'b010));
    clear_hist();
    send_word(1'b0, rnd_word(), 1);
    tick();
    build_exp(12);
    cmp_writes("restart", 1'b0);

    // Back-to-back bytes: a byte lands in every WRITE cycle
    for (int i = 0; i < 3; i++) send_word(1'b0, rnd_word(), 0);
    send_word(1'b0, HALT, 0);
    repeat (3) tick();
    build_exp(12);
    cmp_writes("b2b", 1'b0);

    // Randomized stream with stray i_start pulses while busy
    do_reset();
    clear_hist();
    pulse_start(1'b0);
    nw = $urandom_range(5, 12);
    for (int k = 0; k < nw; k++) begin
      send_word(1'b0, rnd_word(), $urandom_range(0, 3));
      if (k == 2) pulse_start(1'b0);
    end
    send(1'b0, 8'hFF, 1);
    pulse_start(1'b0);
    send(1'b0, 8'hFF, 0); send(1'b0, 8'hFF, 2); send(1'b0, 8'hFF, 0);
    repeat (3) tick();
    build_exp(12);
    cmp_writes("rand", 1'b0);
    chk("rand_done", 48'({done_a, busy_a, ovf_a}), 48'(3'b100));

    // Reset after two bytes, then AA BB CC DD
    pulse_start(1'b0);
    send(1'b0, 8'h11, 0); send(1'b0, 8'h22, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 48'(busy_a), 48'(0));
    tick();
    rst_n = 1'b1;
    tick();
    clear_hist();
    pulse_start(1'b0);
    send(1'b0, 8'hAA, 0); send(1'b0, 8'hBB, 1); send(1'b0, 8'hCC, 0); send(1'b0, 8'hDD, 0);
    chk("aabb_data", 48'(data_a), 48'(32'hAABB_CCDD));
    chk("aabb_addr", 48'(addr_a), 48'(0));
    repeat (2) tick();
    build_exp(12);
    cmp_writes("aabb", 1'b0);

    // Reset during the write strobe drops o_we without a clock
    send_word(1'b0, rnd_word(), 0);
    chk("wrst_we_pre", 48'(we_a), 48'(1));
    rst_n = 1'b0;
    #1;
    chk("wrst_we", 48'(we_a), 48'(0));
    chk("wrst_data", 48'(data_a), 48'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Small memory: four non-halt words overflow
    clear_hist();
    pulse_start(1'b1);
    for (int k = 0; k < 4; k++) send_word(1'b1, rnd_word(), $urandom_range(0, 2));
    repeat (3) tick();
    build_exp(4);
    cmp_writes("ovf", 1'b1);
    chk("ovf_flags", 48'({done_b, busy_b, ovf_b}), 48'(3'b101));
    for (int i = 0; i < 6; i++) send(1'b1, 8'($urandom), 0);
    repeat (2) tick();
    chk("ovf_no_more", 48'(got_b.size()), 48'(4));
    pulse_start(1'b1);
    chk("ovf_clear", 48'({done_b, busy_b, ovf_b}), 48'(3'b010));

    chk("single_cycle_we", 48'(dbl_we), 48'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
